// File: rtl/result_fifo.sv
// result_fifo: FWFT result buffer behind a no-backpressure pipeline stage, with sticky overflow tracking
//   clk, reset        rising-edge clock, synchronous active-high reset
//   valid_in, data_in one-cycle result pulse and value from the upstream stage
//   out_valid/out_data/out_ready  first-word-fall-through consumer interface
//   count, full, empty            occupancy 0..DEPTH
//   overflow, drop_cnt            sticky drop flag and saturating drop counter
module result_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8,
  parameter int CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [CNTW-1:0]          drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [CNTW-1:0]  drop_cnt_q, drop_cnt_d;
  logic             pop, push, drop;
  assign empty     = count_q == '0;
  assign full      = count_q == (AW+1)'(DEPTH);
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign pop  = out_valid & out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push = valid_in & (!full | pop);
  assign drop = valid_in & full & !pop;
  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = (push & !pop) ? count_q + 1'b1 :
                 (pop & !push) ? count_q - 1'b1 : count_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop & !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  // storage is not reset; its contents are only visible through rd_ptr when non-empty
  always_ff @(posedge clk)
    if (!reset && push) mem_q[wr_ptr_q] <= data_in;
endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: table-driven directed check of result_fifo
module tb_result_fifo;
  logic        clk = 1'b0;
  logic        reset, valid_in, out_ready;
  logic [19:0] data_in;
  logic        out_valid, full, empty, overflow;
  logic [19:0] out_data;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;
  int n_cmp = 0;
  int n_bad = 0;

  result_fifo #(.WIDTH(20), .DEPTH(8), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vi, rdy;
    logic [19:0] din;
    logic [3:0]  cnt;
    logic        ov;
    logic [7:0]  dc;
    logic [19:0] dout;
  } vec_t;
  vec_t vq[$];

  function automatic void add(int rst, int vi, int rdy, int din, int cnt, int ov, int dc, int dout);
    vec_t v;
    v.rst = rst[0]; v.vi = vi[0]; v.rdy = rdy[0]; v.din = din[19:0];
    v.cnt = cnt[3:0]; v.ov = ov[0]; v.dc = dc[7:0]; v.dout = dout[19:0];
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic vi, input logic rdy, input logic [19:0] d);
    reset = r; valid_in = vi; out_ready = rdy; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; out_ready = 1'b0; data_in = '0;
    add(1,0,0,0, 0,0,0,0);
    for (int i = 1; i <= 3; i++) add(0,1,0,i, i,0,0,1);
    add(0,0,0,0, 3,0,0,1);
    add(0,0,1,0, 2,0,0,2);
    add(0,0,1,0, 1,0,0,3);
    add(0,0,1,0, 0,0,0,0);
    for (int i = 0; i < 8; i++) add(0,1,0,'h10+i, i+1,0,0,'h10);
    add(0,1,0,'hFFFFF, 8,1,1,'h10);
    for (int k = 1; k <= 8; k++) add(0,0,1,0, 8-k,1,1, k < 8 ? 'h10+k : 0);
    add(1,0,0,0, 0,0,0,0);
    for (int i = 0; i < 8; i++) add(0,1,0,'h20+i, i+1,0,0,'h20);
    add(0,1,1,'hABCDE, 8,0,0,'h21);
    for (int k = 1; k <= 8; k++) add(0,0,1,0, 8-k,0,0, k <= 6 ? 'h21+k : k == 7 ? 'hABCDE : 0);
    for (int i = 0; i < 20; i++) add(0,1,1,'h100+i, 1,0,0,'h100+i);
    add(0,0,1,0, 0,0,0,0);
    for (int i = 0; i < 8; i++) add(0,1,0,'h30+i, i+1,0,0,'h30);
    add(0,1,0,'h77, 8,1,1,'h30);
    for (int k = 1; k <= 3; k++) add(0,0,1,0, 8-k,1,1,'h30+k);
    add(1,1,1,'h99, 0,0,0,0);
    add(0,1,0,'h42, 1,0,0,'h42);
    add(0,0,1,0, 0,0,0,0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].vi, vq[i].rdy, vq[i].din);
      chk("count",     i, 32'(count),     32'(vq[i].cnt));
      chk("out_valid", i, 32'(out_valid), 32'(vq[i].cnt != 0));
      chk("out_data",  i, 32'(out_data),  32'(vq[i].dout));
      chk("full",      i, 32'(full),      32'(vq[i].cnt == 8));
      chk("empty",     i, 32'(empty),     32'(vq[i].cnt == 0));
      chk("overflow",  i, 32'(overflow),  32'(vq[i].ov));
      chk("drop_cnt",  i, 32'(drop_cnt),  32'(vq[i].dc));
    end

    // empty FIFO with ready held: no bypass, one-cycle write-to-read latency
    reset = 1'b0; valid_in = 1'b1; out_ready = 1'b1; data_in = 20'h12345;
    #1;
    chk("nobypass_valid", 0, 32'(out_valid), 0);
    chk("nobypass_data",  0, 32'(out_data), 0);
    @(posedge clk); #1;
    chk("latency_valid", 0, 32'(out_valid), 1);
    chk("latency_data",  0, 32'(out_data), 32'h12345);
    step(0, 0, 1, 0);
    chk("latency_empty", 0, 32'(empty), 1);

    // drop counter saturation
    for (int i = 0; i < 8; i++) step(0, 1, 0, 20'(i));
    for (int i = 0; i < 300; i++) step(0, 1, 0, 20'hBAD);
    chk("sat_drop_cnt", 0, 32'(drop_cnt), 255);
    chk("sat_overflow", 0, 32'(overflow), 1);
    chk("sat_head",     0, 32'(out_data), 0);
    step(1, 0, 0, 0);
    chk("sat_reset_cnt", 0, 32'(drop_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/result_fifo.md
Name: result_fifo

Overview:
- Downstream buffer for the squared-sum/square-root pipeline stage.
- Captures each 20-bit result on the stage's one-cycle valid_out pulse, because that stage has no backpressure.
- Presents results to a consumer through a first-word-fall-through valid/ready interface.
- Tracks occupancy and flags dropped results sticky so the bench and system can detect overrun.

Parameters:
- WIDTH, 20, data width; matches the pipeline result width.
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- CNTW, 8, width of the saturating dropped-result counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- valid_in  input  1  one-cycle pulse marking data_in as a new result; driven by the upstream stage's valid_out.
- data_in  input  WIDTH  result value; driven by the upstream stage's f.
- out_valid  output  1  head entry available.
- out_data  output  WIDTH  head entry value; 0 when empty.
- out_ready  input  1  consumer accepts the head this cycle.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a result was dropped since reset.
- drop_cnt  output  CNTW  number of dropped results, saturating at 2^CNTW-1.

Behaviour:
- Reset: on a clock edge with reset=1, the following all clear to 0: read pointer, write pointer, count, overflow, drop_cnt.
  - As a result, empty=1, full=0, out_valid=0, out_data=0.
  - Memory contents are not cleared and are don't-care.
  - Reset has priority over every other event in the same cycle, including a push or a pop.
- Storage: circular buffer of DEPTH entries. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- pop = out_valid & out_ready.
  - On a pop, the read pointer advances at the clock edge.
  - out_ready while empty is ignored.
- push = valid_in & (!full | pop).
  - On a push, data_in is written at the write pointer and the write pointer advances.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop, or on neither.
- Full with simultaneous valid_in and pop: both occur, the new result is accepted, and count stays at DEPTH.
- Drop condition: valid_in & full & !pop.
  - data_in is discarded and pointers are unchanged.
  - overflow is set to 1 and stays at 1 until reset.
  - drop_cnt increments by 1, holding at 2^CNTW-1 once it reaches that value.
- Empty with valid_in: no bypass. The data appears on out_data with out_valid=1 starting the cycle after the write edge.
  - Write-to-read latency is 1 cycle.
- out_valid = !empty, combinational from registered state.
- out_data = mem[rd_ptr] when out_valid=1, else 0.
  - out_data must hold stable while out_valid=1 and out_ready=0.
- Ordering: results leave in exactly arrival order, with no duplication and no loss except the drops defined above.
- Back-to-back valid_in on consecutive cycles must be accepted every cycle while not full. The upstream stage can emit one result per cycle.
- Reset mid-operation: contents in flight are lost. The next valid_in after reset is written to entry 0 and emerges first.

Test Plan:
- Reset, then push 0x00001, 0x00002, 0x00003 on consecutive cycles with out_ready=0 -> count=3, out_data=0x00001 and stable, empty=0. Then raise out_ready for 3 cycles -> out_data reads 1, 2, 3 in order, then empty=1 and out_data=0.
- Push 8 values 0x10..0x17 with out_ready=0 -> full=1, count=8. A 9th push of 0xFFFFF -> overflow=1, drop_cnt=1. Draining yields 0x10..0x17 only.
- Fill to full, then drive valid_in=1 (data 0xABCDE) and out_ready=1 in the same cycle -> no drop, count stays 8, overflow=0. 0xABCDE emerges last after draining.
- Continuous streaming: push one value per cycle for 20 cycles while out_ready=1 -> count never exceeds 1, all 20 values emerge in order, pointers wrap twice, overflow=0.
- Empty FIFO, push 0x12345 with out_ready=1 held -> out_valid=0 on the push cycle, out_valid=1 with out_data=0x12345 on the next cycle, then empty after that edge.
- Fill 5 entries and set overflow, then assert reset for 1 cycle -> count=0, overflow=0, drop_cnt=0, out_valid=0. The next push of 0x00042 appears as the first output.
